// File: rtl/operand_sel_pipe.sv
// Registered ALU operand selector: picks a full-width source or an extended narrow
// field, behind a two-entry skid buffer with a registered in_ready.
module operand_sel_pipe #(
    parameter  int DATA_W   = 32,
    parameter  int NARROW_W = 5,
    parameter  int NUM_SRC  = 4,
    localparam int SEL_W    = $clog2(NUM_SRC + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_ext,
    input  logic [NUM_SRC*DATA_W-1:0] in_src,
    input  logic [NARROW_W-1:0]       in_narrow,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_err
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic                main_err_q, main_err_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                skid_err_q, skid_err_d;
    logic                in_ready_q, in_ready_d;

    logic [DATA_W-1:0]   sel_data;
    logic                sel_err;
    logic                accept, drain;

    always_comb begin
        sel_data = '0;
        sel_err  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (in_sel == SEL_W'(k)) sel_data = in_src[k*DATA_W +: DATA_W];
        end
        if (in_sel == SEL_W'(NUM_SRC)) begin
            sel_data = {{(DATA_W-NARROW_W){in_ext & in_narrow[NARROW_W-1]}}, in_narrow};
        end else if (in_sel > SEL_W'(NUM_SRC)) begin
            sel_err = 1'b1;
        end
    end

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d     = ONE;
                    main_data_d = sel_data;
                    main_err_d  = sel_err;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    main_data_d = sel_data;
                    main_err_d  = sel_err;
                end else if (accept) begin
                    state_d     = TWO;
                    skid_data_d = sel_data;
                    skid_err_d  = sel_err;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so the only move is promoting the skid entry.
                if (drain) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_err_d  = skid_err_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_err   = main_err_q;

endmodule
